ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiply, divide stays iterative.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [4:0]        rd_q, rd_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // Operand decode at start
  logic            signed_a, signed_b, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, start_ok;

  assign signed_a = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign signed_b = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sa       = signed_a & rs1_data[XLEN-1];
  assign sb       = signed_b & rs2_data[XLEN-1];
  assign mag_a    = sa ? -rs1_data : rs1_data;
  assign mag_b    = sb ? -rs2_data : rs2_data;
  assign div_zero = funct3[2] && (rs2_data == '0);
  assign div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                    (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign start_ok = (state_q == StIdle) && start && !flush;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{sa}}, rs1_data} * {{XLEN{sb}}, rs2_data};
`endif

  // One iteration step. Multiply: acc = {partial high, remaining multiplier}.
  // Divide: acc = {partial remainder, remaining dividend / growing quotient}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     rem_shift, div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] iter_acc;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step  = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = rem_shift - {1'b0, opnd_q};
  assign div_step  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign iter_acc  = op_q[2] ? div_step : mul_step;

  // Sign fix applied to the last iteration's value
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_result;

  assign prod_fix = neg_q ? -iter_acc : iter_acc;
  assign quo      = iter_acc[XLEN-1:0];
  assign rem      = iter_acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    unique case (op_q)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100:                 fix_result = neg_q ? -quo : quo;
      3'b101:                 fix_result = quo;
      3'b110:                 fix_result = rem_neg_q ? -rem : rem;
      3'b111:                 fix_result = rem;
      default:                fix_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          op_d      = funct3;
          rd_d      = rd_in;
          neg_d     = sa ^ sb;
          rem_neg_d = sa;
          cnt_d     = '0;
          opnd_d    = funct3[2] ? mag_b : mag_a;
          acc_d     = funct3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
          state_d   = StCalc;
          if (div_zero) begin
            result_d = funct3[1] ? rs1_data : '1;
            rd_out_d = rd_in;
            done_d   = 1'b1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : rs1_data;
            rd_out_d = rd_in;
            done_d   = 1'b1;
            state_d  = StDone;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!funct3[2]) begin
            result_d = (funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            rd_out_d = rd_in;
            done_d   = 1'b1;
            state_d  = StDone;
          end
`endif
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = iter_acc;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            result_d = fix_result;
            rd_out_d = rd_q;
            done_d   = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign stall  = start_ok || (state_q == StCalc);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops vs. an
// arithmetic reference model. Honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prev_res = '0;
  logic [4:0]  prev_rd  = '0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .stall    (stall),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launches one op in the next cycle and follows it to one cycle past its done pulse.
  // hold=1 keeps start asserted until done; otherwise inputs are scrambled after cycle 0.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold);
    logic [31:0] exp_res;
    logic [31:0] got_res;
    logic [4:0]  got_rd;
    int          lat;
    int          done_cyc;
    int          n_done;
    int          stall_err;
    int          hold_err;
    exp_res   = ref_model(f3, a, b);
    lat       = ref_lat(f3, a, b);
    done_cyc  = -1;
    n_done    = 0;
    stall_err = 0;
    hold_err  = 0;
    got_res   = '0;
    got_rd    = '0;
    @(negedge clk);
    start    = 1'b1;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    #1;
    check_eq("stall_c0", {31'd0, stall}, 32'd1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      if (!hold) begin
        start    = 1'b0;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_in    = 5'($urandom);
      end
      if (done) begin
        n_done++;
        done_cyc = c;
        got_res  = result;
        got_rd   = rd_out;
      end
      if (stall !== (c < lat)) stall_err++;
      if (c < lat && (result !== prev_res || rd_out !== prev_rd)) hold_err++;
      if (c >= lat) start = 1'b0;
    end
    check_eq($sformatf("done_cycle f3=%0d", f3), done_cyc, lat);
    check_eq($sformatf("done_count f3=%0d", f3), n_done, 32'd1);
    check_eq($sformatf("result f3=%0d a=%h b=%h", f3, a, b), got_res, exp_res);
    check_eq($sformatf("rd_out f3=%0d", f3), {27'd0, got_rd}, {27'd0, rd});
    check_eq($sformatf("stall_window f3=%0d", f3), stall_err, 32'd0);
    check_eq($sformatf("result_hold f3=%0d", f3), hold_err, 32'd0);
    prev_res = exp_res;
    prev_rd  = rd;
  endtask

  initial begin
    int fl_done;
    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    funct3   = '0;
    rs1_data = '0;
    rs2_data = '0;
    rd_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_result", result, 32'd0);
    check_eq("reset_rd_out", {27'd0, rd_out}, 32'd0);
    check_eq("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 5'd13, 1'b1);
    run_op(3'd7, 32'd5, 32'd0, 5'd14, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1);

    // Flush a DIV at cycle 10, then launch a MUL at cycle 12
    fl_done = 0;
    @(negedge clk);
    start    = 1'b1;
    funct3   = 3'd4;
    rs1_data = 32'd1000;
    rs2_data = 32'd7;
    rd_in    = 5'd20;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) fl_done++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (done) fl_done++;
    check_eq("flush_stall_c11", {31'd0, stall}, 32'd0);
    check_eq("flush_result_hold", result, prev_res);
    check_eq("flush_rd_hold", {27'd0, rd_out}, {27'd0, prev_rd});
    @(posedge clk);
    #1;
    if (done) fl_done++;
    check_eq("flush_no_done", fl_done, 32'd0);
    run_op(3'd0, 32'h1234_5678, 32'h0000_0100, 5'd21, 1'b0);

    // Reset in the middle of a REM
    @(negedge clk);
    start    = 1'b1;
    funct3   = 3'd6;
    rs1_data = 32'hDEAD_BEEF;
    rs2_data = 32'd13;
    rd_in    = 5'd22;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mid_done", {31'd0, done}, 32'd0);
    check_eq("rst_mid_result", result, 32'd0);
    check_eq("rst_mid_rd_out", {27'd0, rd_out}, 32'd0);
    check_eq("rst_mid_stall", {31'd0, stall}, 32'd0);
    prev_res = '0;
    prev_rd  = '0;
    run_op(3'd6, 32'hDEAD_BEEF, 32'd13, 5'd23, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom_range(1, 31)), ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
